// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and register index type.
package mips_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef logic [AW-1:0] regidx_t;

  localparam regidx_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/rf_read_port.sv
// One combinational register-file read port: r0 forced to zero, same-cycle
// write-through bypass from the committing write-back.
module rf_read_port #(
  parameter int unsigned DW = mips_pkg::DW,
  parameter int unsigned AW = mips_pkg::AW
) (
  input  logic [AW-1:0] rn_i,
  input  logic          wcommit_i,
  input  logic [AW-1:0] wrn_i,
  input  logic [DW-1:0] wdi_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] q_o
);

  // Zero index wins over everything; a committing write to this index wins over the array.
  always_comb begin
    q_o = '0;
    if (rn_i != '0) begin
      if (wcommit_i && (wrn_i == rn_i)) begin
        q_o = wdi_i;
      end else begin
        q_o = rdata_i;
      end
    end
  end

endmodule : rf_read_port

// File: rtl/wb_regfile.sv
// MIPS write-back stage and 32-entry architectural register file with
// bypassing read ports and a committed-write counter.
module wb_regfile #(
  parameter int unsigned DW = mips_pkg::DW,
  parameter int unsigned AW = mips_pkg::AW,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [DW-1:0] wmo,
  input  logic [DW-1:0] walu,
  input  logic [AW-1:0] wrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wdi,
  output logic          wcommit,
  output logic [CW-1:0] wcount
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] regs_q [DEPTH];
  logic [CW-1:0] wcount_q;
  logic [CW-1:0] wcount_d;

  assign wdi     = wm2reg ? wmo : walu;
  assign wcommit = wwreg & (wrn != '0) & ~rst;
  assign wcount  = wcount_q;

  always_comb begin
    wcount_d = wcount_q;
    if (wcommit) begin
      wcount_d = wcount_q + CW'(1);
    end
  end

  // r0 is cleared by reset and never targeted, since wcommit excludes index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      wcount_q <= '0;
    end else begin
      if (wcommit) begin
        regs_q[wrn] <= wdi;
      end
      wcount_q <= wcount_d;
    end
  end

  rf_read_port #(.DW(DW), .AW(AW)) u_port_a (
    .rn_i      (rna),
    .wcommit_i (wcommit),
    .wrn_i     (wrn),
    .wdi_i     (wdi),
    .rdata_i   (regs_q[rna]),
    .q_o       (qa)
  );

  rf_read_port #(.DW(DW), .AW(AW)) u_port_b (
    .rn_i      (rnb),
    .wcommit_i (wcommit),
    .wrn_i     (wrn),
    .wdi_i     (wdi),
    .rdata_i   (regs_q[rnb]),
    .q_o       (qb)
  );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa, qb, wdi;
  logic        wcommit;
  logic [31:0] wcount;
  logic [31:0] qa_s, qb_s, wdi_s;
  logic        wcommit_s;
  logic [3:0]  wcount_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DW(32), .AW(5), .CW(32)) dut (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .wdi(wdi),
    .wcommit(wcommit), .wcount(wcount)
  );

  wb_regfile #(.DW(32), .AW(5), .CW(4)) dut_small (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa_s), .qb(qb_s), .wdi(wdi_s),
    .wcommit(wcommit_s), .wcount(wcount_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and checks happen mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wwreg = 1'b0; wm2reg = 1'b0; wmo = '0; walu = '0;
    wrn = '0; rna = '0; rnb = '0;
    @(negedge clk);
    step();
    rst = 1'b0;

    // Fill r1..r31 with random data.
    for (int i = 1; i < 32; i++) begin
      wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'(i); walu = $urandom;
      step();
    end
    wwreg = 1'b0; #1;
    chk("fill_wcount", wcount, 32'd31);

    // Reset for two cycles while a write to r3 is presented.
    rst = 1'b1; wwreg = 1'b1; wrn = 5'd3; walu = 32'hAAAA_AAAA; rna = 5'd3;
    #1;
    chk("rst_wcommit", {31'd0, wcommit}, 32'd0);
    step();
    chk("rst_no_bypass_r3", qa, 32'd0);
    step();
    rst = 1'b0; wwreg = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i); #1;
      chk("rst_qa", qa, 32'd0);
      chk("rst_qb", qb, 32'd0);
    end
    chk("rst_wcount", wcount, 32'd0);
    chk("rst_wcount_small", {28'd0, wcount_s}, 32'd0);

    // Write-back mux and commit.
    wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h1234_5678; wmo = 32'hDEAD_BEEF; wrn = 5'd5;
    rna = 5'd1; rnb = 5'd2; #1;
    chk("mux_alu_wdi", wdi, 32'h1234_5678);
    chk("mux_alu_wcommit", {31'd0, wcommit}, 32'd1);
    step();
    wm2reg = 1'b1; wrn = 5'd6; #1;
    chk("mux_mem_wdi", wdi, 32'hDEAD_BEEF);
    step();
    wwreg = 1'b0; rna = 5'd5; rnb = 5'd6; #1;
    chk("mux_r5", qa, 32'h1234_5678);
    chk("mux_r6", qb, 32'hDEAD_BEEF);
    chk("mux_wcount", wcount, 32'd2);
    chk("wdi_without_wwreg", wdi, 32'hDEAD_BEEF);

    // r0 protection.
    wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd0; walu = 32'hFFFF_FFFF; rna = 5'd0; #1;
    chk("r0_wcommit", {31'd0, wcommit}, 32'd0);
    chk("r0_qa_same_cycle", qa, 32'd0);
    step();
    wwreg = 1'b0; #1;
    chk("r0_qa_after", qa, 32'd0);
    chk("r0_wcount", wcount, 32'd2);

    // Same-cycle bypass on both ports.
    wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd9; walu = 32'hCAFE_0009; rna = 5'd9; rnb = 5'd9; #1;
    chk("byp_qa", qa, 32'hCAFE_0009);
    chk("byp_qb", qb, 32'hCAFE_0009);
    rnb = 5'd5; #1;
    chk("byp_other_port_array", qb, 32'h1234_5678);
    rnb = 5'd9;
    step();
    wwreg = 1'b0; walu = 32'h0; #1;
    chk("byp_qa_after", qa, 32'hCAFE_0009);
    chk("byp_qb_after", qb, 32'hCAFE_0009);
    chk("byp_wcount", wcount, 32'd3);

    // Reset colliding with a write to r7.
    rst = 1'b1; wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd7; walu = 32'h0000_0077; rna = 5'd7; #1;
    chk("coll_wcommit", {31'd0, wcommit}, 32'd0);
    chk("coll_no_bypass", qa, 32'd0);
    step();
    rst = 1'b0; wwreg = 1'b0; rnb = 5'd5; #1;
    chk("coll_r7", qa, 32'd0);
    chk("coll_r5_cleared", qb, 32'd0);
    chk("coll_wcount", wcount, 32'd0);

    // 17 commits: small counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'(1 + (i % 31)); walu = 32'(i + 100);
      step();
    end
    wwreg = 1'b0; rna = 5'd17; rnb = 5'd1; #1;
    chk("wrap_wcount_small", {28'd0, wcount_s}, 32'd1);
    chk("wrap_wcount_main", wcount, 32'd17);
    chk("wrap_r17", qa, 32'd116);
    chk("wrap_r1", qb, 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile
